// File: rtl/rob_pkg.sv
// Shared widths and constants for the reorder buffer slice.
package rob_pkg;

  localparam int unsigned ROB_DEPTH_DFLT = 16;
  localparam int unsigned ROB_AW_DFLT    = 4;
  localparam int unsigned DATA_W_DFLT    = 32;
  localparam int unsigned REG_AW         = 5;

  localparam logic [REG_AW-1:0] REG_ZERO = '0;

endpackage

// File: rtl/rob_if.sv
// Issue, query, writeback, broadcast and commit signals of the reorder buffer.
interface rob_if import rob_pkg::*; #(
  parameter int unsigned ROB_AW = ROB_AW_DFLT,
  parameter int unsigned DATA_W = DATA_W_DFLT
);

  logic              has_issue;
  logic [REG_AW-1:0] in_rd;
  logic              in_is_store;
  logic              in_is_branch;
  logic              rob_avail;
  logic [ROB_AW-1:0] rob_tail;

  logic [ROB_AW-1:0] query1_robnum;
  logic [ROB_AW-1:0] query2_robnum;
  logic              query1_ready;
  logic              query2_ready;
  logic [DATA_W-1:0] query1_data;
  logic [DATA_W-1:0] query2_data;

  logic              alu_valid;
  logic [ROB_AW-1:0] alu_robnum;
  logic [DATA_W-1:0] alu_data;
  logic              alu_misbranch;
  logic [DATA_W-1:0] alu_target_pc;

  logic              lsb_valid;
  logic [ROB_AW-1:0] lsb_robnum;
  logic [DATA_W-1:0] lsb_data;

  logic              has_rd_ready_1;
  logic              has_rd_ready_2;
  logic [ROB_AW-1:0] ready_robnum_1;
  logic [ROB_AW-1:0] ready_robnum_2;
  logic [DATA_W-1:0] ready_data_1;
  logic [DATA_W-1:0] ready_data_2;

  logic              commit_valid;
  logic [REG_AW-1:0] commit_rd;
  logic [DATA_W-1:0] commit_data;
  logic [ROB_AW-1:0] commit_robnum;
  logic              commit_store;
  logic              has_misbranch;
  logic [DATA_W-1:0] out_target_pc;

  modport slave (
    input  has_issue, in_rd, in_is_store, in_is_branch,
    output rob_avail, rob_tail,
    input  query1_robnum, query2_robnum,
    output query1_ready, query2_ready, query1_data, query2_data,
    input  alu_valid, alu_robnum, alu_data, alu_misbranch, alu_target_pc,
    input  lsb_valid, lsb_robnum, lsb_data,
    output has_rd_ready_1, has_rd_ready_2, ready_robnum_1, ready_robnum_2,
    output ready_data_1, ready_data_2,
    output commit_valid, commit_rd, commit_data, commit_robnum, commit_store,
    output has_misbranch, out_target_pc
  );

  modport master (
    output has_issue, in_rd, in_is_store, in_is_branch,
    input  rob_avail, rob_tail,
    output query1_robnum, query2_robnum,
    input  query1_ready, query2_ready, query1_data, query2_data,
    output alu_valid, alu_robnum, alu_data, alu_misbranch, alu_target_pc,
    output lsb_valid, lsb_robnum, lsb_data,
    input  has_rd_ready_1, has_rd_ready_2, ready_robnum_1, ready_robnum_2,
    input  ready_data_1, ready_data_2,
    input  commit_valid, commit_rd, commit_data, commit_robnum, commit_store,
    input  has_misbranch, out_target_pc
  );

endinterface

// File: rtl/rob.sv
// Reorder buffer: in-order allocation, out-of-order writeback with wakeup
// broadcast, in-order commit of one entry per cycle, flush on misbranch.
module rob import rob_pkg::*; #(
  parameter int unsigned ROB_DEPTH = ROB_DEPTH_DFLT,
  parameter int unsigned ROB_AW    = ROB_AW_DFLT,
  parameter int unsigned DATA_W    = DATA_W_DFLT
) (
  input  logic  clk,
  input  logic  rst,
  input  logic  rdy,
  rob_if.slave  bus
);

  localparam logic [ROB_AW:0]   FULL_CNT = (ROB_AW+1)'(ROB_DEPTH);
  localparam logic [ROB_AW:0]   CNT_ONE  = (ROB_AW+1)'(1);
  localparam logic [ROB_AW-1:0] PTR_ONE  = (ROB_AW)'(1);

  logic [ROB_DEPTH-1:0] busy_q;
  logic [ROB_DEPTH-1:0] ready_q;
  logic [ROB_DEPTH-1:0] store_q;
  logic [ROB_DEPTH-1:0] branch_q;
  logic [ROB_DEPTH-1:0] mis_q;
  logic [REG_AW-1:0]    rd_q    [ROB_DEPTH];
  logic [DATA_W-1:0]    value_q [ROB_DEPTH];
  logic [DATA_W-1:0]    tgt_q   [ROB_DEPTH];

  logic [ROB_AW-1:0] head_q;
  logic [ROB_AW-1:0] tail_q;
  logic [ROB_AW:0]   count_q;

  logic avail;
  logic alloc;
  logic alu_acc;
  logic lsb_acc;
  logic do_commit;
  logic flush;

  assign avail     = (count_q != FULL_CNT);
  assign alloc     = bus.has_issue && avail && !bus.has_misbranch;
  assign alu_acc   = bus.alu_valid && busy_q[bus.alu_robnum];
  assign lsb_acc   = bus.lsb_valid && busy_q[bus.lsb_robnum];
  assign do_commit = busy_q[head_q] && ready_q[head_q];
  assign flush     = do_commit && branch_q[head_q] && mis_q[head_q];

  assign bus.rob_avail = avail;
  assign bus.rob_tail  = tail_q;

  // Operand lookup with same-cycle writeback forwarding (ALU checked last so it wins).
  always_comb begin
    bus.query1_ready = busy_q[bus.query1_robnum] && ready_q[bus.query1_robnum];
    bus.query1_data  = value_q[bus.query1_robnum];
    bus.query2_ready = busy_q[bus.query2_robnum] && ready_q[bus.query2_robnum];
    bus.query2_data  = value_q[bus.query2_robnum];
    if (lsb_acc && (bus.lsb_robnum == bus.query1_robnum)) begin
      bus.query1_ready = 1'b1;
      bus.query1_data  = bus.lsb_data;
    end
    if (alu_acc && (bus.alu_robnum == bus.query1_robnum)) begin
      bus.query1_ready = 1'b1;
      bus.query1_data  = bus.alu_data;
    end
    if (lsb_acc && (bus.lsb_robnum == bus.query2_robnum)) begin
      bus.query2_ready = 1'b1;
      bus.query2_data  = bus.lsb_data;
    end
    if (alu_acc && (bus.alu_robnum == bus.query2_robnum)) begin
      bus.query2_ready = 1'b1;
      bus.query2_data  = bus.alu_data;
    end
  end

  // Entry array, pointers and all registered outputs; flush overrides the
  // allocation and commit updates made earlier in the same block.
  always_ff @(posedge clk) begin
    if (rst) begin
      head_q             <= '0;
      tail_q             <= '0;
      count_q            <= '0;
      busy_q             <= '0;
      ready_q            <= '0;
      store_q            <= '0;
      branch_q           <= '0;
      mis_q              <= '0;
      bus.has_rd_ready_1 <= 1'b0;
      bus.has_rd_ready_2 <= 1'b0;
      bus.ready_robnum_1 <= '0;
      bus.ready_robnum_2 <= '0;
      bus.ready_data_1   <= '0;
      bus.ready_data_2   <= '0;
      bus.commit_valid   <= 1'b0;
      bus.commit_rd      <= '0;
      bus.commit_data    <= '0;
      bus.commit_robnum  <= '0;
      bus.commit_store   <= 1'b0;
      bus.has_misbranch  <= 1'b0;
      bus.out_target_pc  <= '0;
    end else if (rdy) begin
      if (lsb_acc) begin
        value_q[bus.lsb_robnum] <= bus.lsb_data;
        ready_q[bus.lsb_robnum] <= 1'b1;
      end
      if (alu_acc) begin
        value_q[bus.alu_robnum] <= bus.alu_data;
        ready_q[bus.alu_robnum] <= 1'b1;
        mis_q[bus.alu_robnum]   <= bus.alu_misbranch;
        tgt_q[bus.alu_robnum]   <= bus.alu_target_pc;
      end

      bus.has_rd_ready_1 <= alu_acc;
      if (alu_acc) begin
        bus.ready_robnum_1 <= bus.alu_robnum;
        bus.ready_data_1   <= bus.alu_data;
      end
      bus.has_rd_ready_2 <= lsb_acc;
      if (lsb_acc) begin
        bus.ready_robnum_2 <= bus.lsb_robnum;
        bus.ready_data_2   <= bus.lsb_data;
      end

      bus.commit_valid  <= do_commit && (rd_q[head_q] != REG_ZERO) && !store_q[head_q];
      bus.commit_store  <= do_commit && store_q[head_q];
      bus.has_misbranch <= flush;
      if (do_commit) begin
        bus.commit_rd     <= rd_q[head_q];
        bus.commit_data   <= value_q[head_q];
        bus.commit_robnum <= head_q;
        busy_q[head_q]    <= 1'b0;
        head_q            <= head_q + PTR_ONE;
      end
      if (flush) begin
        bus.out_target_pc <= tgt_q[head_q];
      end

      if (alloc) begin
        busy_q[tail_q]   <= 1'b1;
        ready_q[tail_q]  <= 1'b0;
        mis_q[tail_q]    <= 1'b0;
        store_q[tail_q]  <= bus.in_is_store;
        branch_q[tail_q] <= bus.in_is_branch;
        rd_q[tail_q]     <= bus.in_rd;
        tail_q           <= tail_q + PTR_ONE;
      end

      if (alloc && !do_commit) begin
        count_q <= count_q + CNT_ONE;
      end else if (!alloc && do_commit) begin
        count_q <= count_q - CNT_ONE;
      end

      if (flush) begin
        head_q  <= '0;
        tail_q  <= '0;
        count_q <= '0;
        busy_q  <= '0;
      end
    end
  end

endmodule

// File: doc/rob.md
Name: rob

Overview:
- Reorder buffer for the out-of-order RISC-V core. Entries are allocated in program order at issue.
- Captures ALU and load/store results and broadcasts them back to the reservation station and LSB wakeup ports (`has_rd_ready_1/2`, `ready_robnum_*`, `ready_data_*`).
- Commits one entry per cycle to the register file, releases stores, and raises `has_misbranch` to flush the machine.

Parameters:
- ROB_DEPTH, 16, number of entries; must be a power of two.
- ROB_AW, 4, robnum width, log2(ROB_DEPTH).
- DATA_W, 32, data and address width.

Ports:
- clk  in  1  system clock
- rst  in  1  synchronous active-high reset
- rdy  in  1  global ready; when low all state and outputs hold
- has_issue  in  1  allocate entry at tail this cycle
- in_rd  in  5  destination architectural register (0 = none)
- in_is_store  in  1  entry is a store
- in_is_branch  in  1  entry is a branch or jump
- rob_avail  out  1  combinational: count < ROB_DEPTH
- rob_tail  out  ROB_AW  combinational: robnum the next allocation receives
- query1_robnum, query2_robnum  in  ROB_AW  operand lookups from issue
- query1_ready, query2_ready  out  1  combinational: entry busy and result written
- query1_data, query2_data  out  DATA_W  combinational: entry value
- alu_valid  in  1  ALU result valid
- alu_robnum  in  ROB_AW  ALU result tag
- alu_data  in  DATA_W  ALU result value
- alu_misbranch  in  1  branch resolved opposite to prediction
- alu_target_pc  in  DATA_W  correct next PC
- lsb_valid  in  1  LSB result valid
- lsb_robnum  in  ROB_AW  LSB result tag
- lsb_data  in  DATA_W  LSB result value
- has_rd_ready_1, has_rd_ready_2  out  1  registered broadcast valids (1 = ALU path, 2 = LSB path)
- ready_robnum_1, ready_robnum_2  out  ROB_AW  broadcast tags
- ready_data_1, ready_data_2  out  DATA_W  broadcast values
- commit_valid  out  1  registered: register write this cycle
- commit_rd  out  5  register written
- commit_data  out  DATA_W  value written
- commit_robnum  out  ROB_AW  robnum of the committed entry
- commit_store  out  1  registered: LSB may perform head store `commit_robnum`
- has_misbranch  out  1  registered one-cycle flush pulse
- out_target_pc  out  DATA_W  redirect PC, valid while `has_misbranch` is high

Behaviour:
- Reset (`rst` high at posedge): head=tail=count=0, all busy/ready flags clear, every registered output 0.
  - Combinational outputs after reset: `rob_avail`=1, `rob_tail`=0.
- `rdy` low: no state change, registered outputs hold. `rst` overrides `rdy`.
- Per-entry state: busy, ready, rd, value, is_store, is_branch, misbranch, target_pc.
- Allocation (`has_issue` && count<ROB_DEPTH && !has_misbranch):
  - entry[tail] loads busy=1, ready=0, misbranch=0.
  - tail increments, wrapping mod ROB_DEPTH.
  - `has_issue` while full is dropped with no state change.
- Writeback: `alu_valid` writes value, ready=1, misbranch and target_pc into entry[alu_robnum]; `lsb_valid` writes value and ready=1 into entry[lsb_robnum].
  - A writeback to a non-busy entry is ignored.
  - ALU and LSB writing the same robnum in one cycle is illegal; the ALU write wins.
- Broadcast: each accepted writeback also appears on its broadcast port the next cycle. ALU → port 1, LSB → port 2.
  - Valid pulses for exactly one cycle.
  - Latency is one cycle from writeback to broadcast.
- Query: combinational read of entry[query*_robnum].
  - A writeback arriving in the same cycle is forwarded: the port reports ready=1 with the incoming data.
- Commit (head busy && head ready): one entry per cycle; busy cleared, head increments.
  - Register write: `commit_valid`=1 when rd!=0 and the entry is not a store; `commit_rd`, `commit_data`, `commit_robnum` driven.
  - Stores: `commit_store`=1 with `commit_robnum`=head.
  - Mispredicted branches: `has_misbranch`=1, `out_target_pc`=target_pc. On that same edge head, tail, count and all busy flags clear. Allocation is blocked during the following cycle while the pulse is high.
  - A jump with rd!=0 writes its link register in the same commit as the flush.
- Count: +1 on allocation, -1 on commit, unchanged when both occur.
  - Simultaneous allocation and commit at full is allowed only when count<ROB_DEPTH at the start of the cycle (`rob_avail` gates it).
  - Simultaneous allocation and commit at empty cannot happen, because a new entry is not ready.
- Wrap-around: robnums are entry indices; tail=15 allocates 15, then 0.

Decomposition:
- `config.v` additions:
  - `Rob_Addr_Len` [3:0]
  - `Rob_Size` [15:0]
  - `Reg_Addr_Len` [4:0]
  - the existing `Data_Len`, `Addr_Len`, `True`/`False`, `Zero_Data`
- No sub-module: the entry array, the head/tail/count counters and the output registers live in one file.

Test Plan:
- Reset, then issue 3 ops (rd=5,6,7) → `rob_tail`=3, `rob_avail`=1, no commit.
- ALU writes robnum 1 data 0x11, then robnum 0 data 0x10 → broadcast port 1 one cycle after each.
  - Commit rd5=0x10 then rd6=0x11 on consecutive cycles.
- Fill 16 entries → `rob_avail`=0 and a 17th `has_issue` is ignored.
  - Ready and commit head → `rob_avail`=1; next allocation gets robnum 0 after tail wraps from 15.
- Query robnum 2 in the same cycle LSB writes robnum 2 data 0xABCD → `query1_ready`=1, `query1_data`=0xABCD.
  - Broadcast port 2 next cycle.
- Branch at robnum 4 with `alu_misbranch`=1, target 0x1040 → at commit, `has_misbranch` pulses 1 cycle with `out_target_pc`=0x1040.
  - Tail=head=0, a `has_issue` during the pulse is ignored, and younger ready entries never commit.
- Store entry commits → `commit_store`=1, `commit_valid`=0.
  - With `rdy`=0 held 3 cycles mid-stream, all outputs freeze and resume unchanged.
